// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer for the EX stage.
// Owns the HI/LO registers and holds MDBusy for the fixed multi-cycle latency
// of MULT/MULTU/DIV/DIVU. The arithmetic is computed from operands captured
// when the operation is accepted; the result is written in one step on the
// final busy edge so that HI/LO never show partial values.
module md_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,   // 1..15
   parameter int unsigned DIV_CYCLES  = 10   // 1..15
) (
   input  logic        clk,
   input  logic        reset,     // asynchronous, active-low
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        dis,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_e;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
   localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] a_q;          // dividend / multiplicand
   logic [31:0] b_q;          // divisor / multiplier
   logic        signed_q;     // operation treats operands as two's complement
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        accept;
   logic [31:0] hi_d;         // result destined for HI at completion
   logic [31:0] lo_d;         // result destined for LO at completion
   logic        write_d;      // completion actually updates HI/LO

   // Working values of the arithmetic datapath.
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   assign accept = start & ~dis & (state_q == S_IDLE);

   // MDBusy is combinational so an MD instruction waiting in ID stalls in
   // the very cycle the accepted operation sits in EX.
   assign busy = (state_q != S_IDLE) | (accept & ~op[2]);

   assign hi = hi_q;
   assign lo = lo_q;

   // Result datapath: 64-bit product or quotient/remainder of latched operands.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, starting
      // with these defaults, so no latch is inferred.
      hi_d    = hi_q;
      lo_d    = lo_q;
      write_d = 1'b0;

      // Sign-extending to 64 bits makes the low 64 bits of an unsigned
      // multiply equal to the signed product, so one multiplier serves both.
      a_ext = {{32{signed_q & a_q[31]}}, a_q};
      b_ext = {{32{signed_q & b_q[31]}}, b_q};
      prod  = a_ext * b_ext;

      // Signed division is done on magnitudes and the signs restored after:
      // quotient truncates toward zero, remainder follows the dividend.
      // 0x80000000 / -1 yields magnitude 0x80000000, whose negation is itself.
      a_neg = signed_q & a_q[31];
      b_neg = signed_q & b_q[31];
      a_mag = a_neg ? (32'd0 - a_q) : a_q;
      b_mag = b_neg ? (32'd0 - b_q) : b_q;
      b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag = a_mag / b_div;
      r_mag = a_mag % b_div;

      if (state_q == S_MUL) begin
         hi_d    = prod[63:32];
         lo_d    = prod[31:0];
         write_d = 1'b1;
      end else if (state_q == S_DIV) begin
         hi_d    = a_neg ? (32'd0 - r_mag) : r_mag;
         lo_d    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
         // A zero divisor still costs the full latency but leaves HI/LO alone.
         write_d = (b_q != 32'd0);
      end
   end

   // Sequencer FSM: accept, count down the busy window, commit HI/LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         signed_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        a_q      <= rs_val;
                        b_q      <= rt_val;
                        signed_q <= ~op[0];
                        cnt_q    <= MULT_LOAD;
                        state_q  <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        a_q      <= rs_val;
                        b_q      <= rt_val;
                        signed_q <= ~op[0];
                        cnt_q    <= DIV_LOAD;
                        state_q  <= S_DIV;
                     end
                     OP_MTHI: hi_q <= rs_val;
                     OP_MTLO: lo_q <= rs_val;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               // Requests arriving here are ignored; the operation runs out.
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= S_IDLE;
                  if (write_d) begin
                     hi_q <= hi_d;
                     lo_q <= lo_d;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed scenarios plus randomized operations,
// checked against an arithmetic reference model of HI/LO and busy timing.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        dis;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  // Reference copy of the architectural HI/LO registers.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .dis    (dis),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  // Architectural result of an MD operation from plain integer arithmetic.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start  = 1'b0;
    op     = 3'd7;
    dis    = 1'b0;
    rs_val = 32'd0;
    rt_val = 32'd0;
  endtask

  // Issue one MULT/DIV-class op; check busy window, stable HI/LO, result.
  // disturb: 0 quiet, 1 random requests while busy, 2 MTHI every busy cycle.
  task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, input string tag);
    logic [31:0] eh, el;
    bit          wr;
    int          n;
    ref_md(o, a, b, eh, el, wr);
    n = (o < 3'd2) ? MC : DC;
    start = 1'b1; op = o; dis = 1'b0; rs_val = a; rt_val = b;
    #3;
    check(busy === 1'b1, $sformatf("%s accept_busy: got %b want 1", tag, busy));
    next_cycle();
    for (int i = 1; i <= n; i++) begin
      case (disturb)
        1: begin
          start = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
          dis = 1'($urandom_range(0, 1));
        end
        2: begin start = 1'b1; op = 3'd4; dis = 1'b0; end
        default: begin start = 1'b0; dis = 1'b0; end
      endcase
      rs_val = $urandom; rt_val = $urandom;
      #3;
      check(busy === 1'b1 && hi === m_hi && lo === m_lo,
            $sformatf("%s busy_cycle%0d: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                      tag, i, busy, hi, lo, m_hi, m_lo));
      next_cycle();
    end
    start = 1'b0;
    if (wr) begin m_hi = eh; m_lo = el; end
    #3;
    check(busy === 1'b0 && hi === m_hi && lo === m_lo,
          $sformatf("%s done: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                    tag, busy, hi, lo, m_hi, m_lo));
    next_cycle();
    idle_inputs();
  endtask

  // MTHI/MTLO: no busy, target written at the accepting edge.
  task automatic do_move(input logic [2:0] o, input logic [31:0] a, input string tag);
    start = 1'b1; op = o; dis = 1'b0; rs_val = a; rt_val = $urandom;
    #3;
    check(busy === 1'b0, $sformatf("%s move_busy: got %b want 0", tag, busy));
    next_cycle();
    idle_inputs();
    if (o == 3'd4) m_hi = a; else m_lo = a;
    #3;
    check(hi === m_hi && lo === m_lo,
          $sformatf("%s move_result: hi=%h lo=%h want hi=%h lo=%h", tag, hi, lo, m_hi, m_lo));
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    check(busy === 1'b0 && hi === 32'd0 && lo === 32'd0,
          $sformatf("reset_state: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo));
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_mult();
    issue_op(3'd0, 32'd3, 32'hFFFF_FFFE, 0, "mult_neg");
    check(hi === 32'hFFFF_FFFF && lo === 32'hFFFF_FFFA,
          $sformatf("mult_const: hi=%h lo=%h want ffffffff/fffffffa", hi, lo));
    issue_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, "multu");
    check(hi === 32'h0000_0001 && lo === 32'hFFFF_FFFE,
          $sformatf("multu_const: hi=%h lo=%h want 00000001/fffffffe", hi, lo));
  endtask

  task automatic test_div();
    issue_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    check(hi === 32'hFFFF_FFFF && lo === 32'hFFFF_FFFD,
          $sformatf("div_const: hi=%h lo=%h want ffffffff/fffffffd", hi, lo));
    issue_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    check(hi === 32'h0 && lo === 32'h8000_0000,
          $sformatf("div_ovf_const: hi=%h lo=%h want 00000000/80000000", hi, lo));
  endtask

  task automatic test_div_zero();
    do_move(3'd4, 32'h11, "mthi_pre");
    do_move(3'd5, 32'h22, "mtlo_pre");
    issue_op(3'd3, 32'd5, 32'd0, 0, "divu_zero");
    check(hi === 32'h11 && lo === 32'h22,
          $sformatf("divu_zero_const: hi=%h lo=%h want 00000011/00000022", hi, lo));
  endtask

  task automatic test_dis();
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; op = 3'(i); dis = 1'b1; rs_val = $urandom; rt_val = $urandom;
      #3;
      check(busy === 1'b0, $sformatf("dis_busy op%0d: got %b want 0", i, busy));
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #3;
      check(busy === 1'b0 && hi === m_hi && lo === m_lo,
            $sformatf("dis_hold: busy=%b hi=%h lo=%h want 0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo));
      next_cycle();
    end
  endtask

  task automatic test_mtlo();
    do_move(3'd5, 32'h0000_ABCD, "mtlo");
    check(lo === 32'h0000_ABCD, $sformatf("mtlo_const: lo=%h want 0000abcd", lo));
  endtask

  task automatic test_busy_ignore();
    issue_op(3'd2, 32'd100, 32'd7, 2, "div_mthi_ignored");
    check(hi === 32'd2 && lo === 32'd14,
          $sformatf("busy_ignore_const: hi=%h lo=%h want 00000002/0000000e", hi, lo));
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'd2; dis = 1'b0; rs_val = 32'd1000; rt_val = 32'd3;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    // Busy cycle 4 of the divide.
    #3;
    check(busy === 1'b1, $sformatf("reset_mid_prebusy: got %b want 1", busy));
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    check(busy === 1'b0 && hi === 32'd0 && lo === 32'd0,
          $sformatf("reset_mid_async: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo));
    next_cycle();
    reset = 1'b1;
    next_cycle();
    issue_op(3'd0, 32'd2, 32'd3, 0, "mult_after_reset");
    check(lo === 32'd6 && hi === 32'd0,
          $sformatf("mult_after_reset_const: hi=%h lo=%h want 00000000/00000006", hi, lo));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] o;
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(0, 5));
      if (o >= 3'd4) do_move(o, $urandom, "rand_move");
      else issue_op(o, pick_operand(), pick_operand(), int'($urandom_range(0, 1)), "rand_op");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_dis();
    test_mtlo();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the EX stage. Owns the HI/LO registers and models the fixed multi-cycle latency of MULT/MULTU/DIV/DIVU.
- Sources the MDBusy signal consumed by pipeline hazard control. Accepts the flush-driven dis_MULTDIV so that squashed instructions never start the unit or write HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles after a multiply is accepted (1..15).
- DIV_CYCLES, 10, busy cycles after a divide is accepted (1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- start  input  1  EX-stage instruction is an MD operation this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- dis  input  1  flush disable (dis_MULTDIV); blocks new operations
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO data)
- rt_val  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  MDBusy to pipeline control
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset low, async): state IDLE, counter 0, hi=0, lo=0, latched operands 0, busy=0.
- States are IDLE, MUL and DIV. A 4-bit down-counter tracks the remaining busy cycles.
- accept = start & ~dis & (state==IDLE).
- busy = (state!=IDLE) | (accept & op<=3). It is combinational so an MD instruction in ID stalls in the same cycle the op enters.
- IDLE, accept, op 0/1: latch rs_val, rt_val and signedness. Go to MUL with counter=MULT_CYCLES.
- IDLE, accept, op 2/3: same latching. Go to DIV with counter=DIV_CYCLES.
- IDLE, accept, op 4: hi<=rs_val at this edge. State stays IDLE; busy stays 0.
- IDLE, accept, op 5: lo<=rs_val at this edge. State stays IDLE; busy stays 0.
- Op 6/7, or start with dis high: no effect.
- MUL/DIV: counter decrements every edge. At the edge where counter==1, the result loads into hi/lo and state returns to IDLE.
- Timing: accept at cycle t gives busy high in cycles t..t+N. New hi/lo are first visible in cycle t+N+1, the same cycle busy falls.
- hi/lo keep their old values for the whole operation.
- start while state!=IDLE is ignored, whatever op is. Hazard control guarantees this does not happen; the block is robust anyway.
- dis does not abort an operation already in progress. The committed MD instruction completes.
- MULT: {hi,lo} = signed 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divisor 0 (DIV or DIVU): full DIV_CYCLES busy, hi/lo unchanged at completion.
- Reset asserted mid-operation returns immediately to the reset state. No partial write.
- Results come from the latched operands only. Changes on rs_val/rt_val after accept have no effect.

Test Plan:
- MULT rs=3, rt=0xFFFFFFFE: start 1 cycle. Busy high 6 cycles (t..t+5). Cycle t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles following accept.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 with prior hi=0x11, lo=0x22: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- start=1, op=0, dis=1 -> busy stays 0 and hi/lo unchanged.
- MTLO rs=0xABCD, dis=0 -> lo=0xABCD next cycle, busy never asserted.
- Issue DIV, then drop reset low at busy cycle 4 -> busy=0, hi=lo=0 asynchronously. Release reset; a new MULT 2*3 completes with lo=6.
- Issue MTHI while DIV is busy -> ignored. hi gets the DIV result only.
